// File: rtl/can_fault_counters_if.sv
// ---------------------------------------------------------------------------
// can_fault_counters_if
// Purpose : bundles the MACFSM request/bit-sample inputs and the fault
//           confinement status outputs of can_fault_counters.
// Signals :
//   inc_tec8, dec_tec            transmit error / success requests (level)
//   inc_rec1, inc_rec8, dec_rec  receive error / success requests (level)
//   bit_tick, rx_bit             bit sample strobe and sampled level (1=recessive)
//   tec_count, rec_count         low 8 bits of TEC / REC
//   err_warning                  either counter at or above the warning limit
//   fault_state, bus_off         00 active, 01 passive, 10 bus-off
//   recov_count                  bus-off recovery sequences completed
// Modports: master drives the requests, slave is the counter block.
// ---------------------------------------------------------------------------
interface can_fault_counters_if #(
    parameter int RECOV_SEQ = 128
);
    localparam int RW = $clog2(RECOV_SEQ + 1);

    logic          inc_tec8;
    logic          dec_tec;
    logic          inc_rec1;
    logic          inc_rec8;
    logic          dec_rec;
    logic          bit_tick;
    logic          rx_bit;
    logic [7:0]    tec_count;
    logic [7:0]    rec_count;
    logic          err_warning;
    logic [1:0]    fault_state;
    logic          bus_off;
    logic [RW-1:0] recov_count;

    modport master (
        output inc_tec8, dec_tec, inc_rec1, inc_rec8, dec_rec, bit_tick, rx_bit,
        input  tec_count, rec_count, err_warning, fault_state, bus_off, recov_count
    );

    modport slave (
        input  inc_tec8, dec_tec, inc_rec1, inc_rec8, dec_rec, bit_tick, rx_bit,
        output tec_count, rec_count, err_warning, fault_state, bus_off, recov_count
    );
endinterface

// File: rtl/can_fault_counters.sv
// ---------------------------------------------------------------------------
// can_fault_counters
// Purpose : CAN fault confinement. Holds TEC and REC, derives the
//           error-active / error-passive / bus-off state and performs the
//           bus-off recovery (RECOV_SEQ runs of RECOV_BITS recessive bits).
// Ports   :
//   clock  system clock, rising edge
//   reset  asynchronous active-high reset, clears all state
//   bus    can_fault_counters_if.slave (requests in, status out)
// ---------------------------------------------------------------------------
module can_fault_counters #(
    parameter int CNT_W       = 9,
    parameter int WARN_LIM    = 96,
    parameter int PASSIVE_LIM = 128,
    parameter int BUSOFF_LIM  = 256,
    parameter int REC_RELOAD  = 120,
    parameter int RECOV_BITS  = 11,
    parameter int RECOV_SEQ   = 128
) (
    input  logic                 clock,
    input  logic                 reset,
    can_fault_counters_if.slave  bus
);
    localparam int RW = $clog2(RECOV_SEQ + 1);
    localparam int BW = $clog2(RECOV_BITS + 1);

    localparam logic [CNT_W-1:0] L_WARN    = CNT_W'(WARN_LIM);
    localparam logic [CNT_W-1:0] L_PASSIVE = CNT_W'(PASSIVE_LIM);
    localparam logic [CNT_W-1:0] L_BUSOFF  = CNT_W'(BUSOFF_LIM);
    localparam logic [CNT_W-1:0] L_RELOAD  = CNT_W'(REC_RELOAD);
    localparam logic [CNT_W-1:0] L_SAT     = {CNT_W{1'b1}};
    localparam logic [BW-1:0]    L_BITS_M1 = BW'(RECOV_BITS - 1);
    localparam logic [RW-1:0]    L_SEQ     = RW'(RECOV_SEQ);

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'b00,
        ST_PASSIVE = 2'b01,
        ST_BUSOFF  = 2'b10
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_tec;
    logic [CNT_W-1:0] r_rec;
    logic             r_tec_edge;
    logic             r_rec_edge;
    logic [BW-1:0]    r_bit_cnt;
    logic [RW-1:0]    r_recov;

    logic             w_tec_grp;
    logic             w_rec_grp;
    logic             w_in_busoff;
    logic             w_tec_acc;
    logic             w_rec_acc;
    logic [CNT_W-1:0] w_tec_nxt;
    logic [CNT_W-1:0] w_rec_nxt;
    logic [CNT_W:0]   w_rec_sum;
    logic [BW-1:0]    w_bit_nxt;
    logic [RW-1:0]    w_recov_nxt;
    logic             w_recov_done;
    state_t           w_state_nxt;

    // Request grouping and edge acceptance; bus-off freezes both counters.
    always_comb begin
        w_tec_grp   = bus.inc_tec8 | bus.dec_tec;
        w_rec_grp   = bus.inc_rec1 | bus.inc_rec8 | bus.dec_rec;
        w_in_busoff = (r_state == ST_BUSOFF);
        w_tec_acc   = w_tec_grp & ~r_tec_edge & ~w_in_busoff;
        w_rec_acc   = w_rec_grp & ~r_rec_edge & ~w_in_busoff;
    end

    // TEC next value: +8 below the bus-off limit, -1 above zero, +8 wins.
    always_comb begin
        w_tec_nxt = r_tec;
        if (w_tec_acc) begin
            if (bus.inc_tec8) begin
                if (r_tec < L_BUSOFF) begin
                    w_tec_nxt = r_tec + CNT_W'(8);
                end else begin
                    w_tec_nxt = r_tec;
                end
            end else if (r_tec != '0) begin
                w_tec_nxt = r_tec - CNT_W'(1);
            end else begin
                w_tec_nxt = r_tec;
            end
        end else begin
            w_tec_nxt = r_tec;
        end
    end

    // REC next value: saturating increments, reload-or-decrement on success.
    always_comb begin
        w_rec_sum = {1'b0, r_rec} + (CNT_W+1)'(bus.inc_rec8 ? 4'd8 : 4'd1);
        w_rec_nxt = r_rec;
        if (w_rec_acc) begin
            if (bus.inc_rec8 | bus.inc_rec1) begin
                if (w_rec_sum > {1'b0, L_SAT}) begin
                    w_rec_nxt = L_SAT;
                end else begin
                    w_rec_nxt = w_rec_sum[CNT_W-1:0];
                end
            end else if (r_rec >= L_PASSIVE) begin
                w_rec_nxt = L_RELOAD;
            end else if (r_rec != '0) begin
                w_rec_nxt = r_rec - CNT_W'(1);
            end else begin
                w_rec_nxt = r_rec;
            end
        end else begin
            w_rec_nxt = r_rec;
        end
    end

    // Bus-off recovery: count runs of recessive bits; a dominant bit restarts the run.
    always_comb begin
        w_bit_nxt   = r_bit_cnt;
        w_recov_nxt = r_recov;
        if (w_in_busoff && bus.bit_tick) begin
            if (bus.rx_bit) begin
                if (r_bit_cnt == L_BITS_M1) begin
                    w_bit_nxt   = '0;
                    w_recov_nxt = r_recov + RW'(1);
                end else begin
                    w_bit_nxt   = r_bit_cnt + BW'(1);
                end
            end else begin
                w_bit_nxt = '0;
            end
        end else begin
            w_bit_nxt   = r_bit_cnt;
            w_recov_nxt = r_recov;
        end
        w_recov_done = w_in_busoff && (w_recov_nxt == L_SEQ);
    end

    // Next fault state from next counter values so it moves with the counters.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BUSOFF: begin
                w_state_nxt = w_recov_done ? ST_ACTIVE : ST_BUSOFF;
            end
            default: begin
                // Active, passive and the unused encoding all re-evaluate from the counters.
                if (w_tec_nxt >= L_BUSOFF) begin
                    w_state_nxt = ST_BUSOFF;
                end else if ((w_tec_nxt >= L_PASSIVE) || (w_rec_nxt >= L_PASSIVE)) begin
                    w_state_nxt = ST_PASSIVE;
                end else begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
        endcase
    end

    // State registers; completing recovery clears every counter on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_ACTIVE;
            r_tec      <= '0;
            r_rec      <= '0;
            r_tec_edge <= 1'b0;
            r_rec_edge <= 1'b0;
            r_bit_cnt  <= '0;
            r_recov    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tec_edge <= w_tec_grp;
            r_rec_edge <= w_rec_grp;
            if (w_recov_done) begin
                r_tec     <= '0;
                r_rec     <= '0;
                r_bit_cnt <= '0;
                r_recov   <= '0;
            end else begin
                r_tec     <= w_tec_nxt;
                r_rec     <= w_rec_nxt;
                r_bit_cnt <= w_bit_nxt;
                r_recov   <= w_recov_nxt;
            end
        end
    end

    assign bus.tec_count   = r_tec[7:0];
    assign bus.rec_count   = r_rec[7:0];
    assign bus.err_warning = (r_tec >= L_WARN) | (r_rec >= L_WARN);
    assign bus.fault_state = r_state;
    assign bus.bus_off     = (r_state == ST_BUSOFF);
    assign bus.recov_count = r_recov;
endmodule

// File: tb/tb_can_fault_counters.sv
// ---------------------------------------------------------------------------
// tb_can_fault_counters
// Self-checking bench: a table of hand-computed vectors, hand-written
// sequences for the multi-cycle cases, and random stimulus against a
// rule-level reference model.
// ---------------------------------------------------------------------------
module tb_can_fault_counters;
    localparam logic [6:0] T8 = 7'b1000000;
    localparam logic [6:0] TD = 7'b0100000;
    localparam logic [6:0] R1 = 7'b0010000;
    localparam logic [6:0] R8 = 7'b0001000;
    localparam logic [6:0] RD = 7'b0000100;
    localparam logic [6:0] TK = 7'b0000010;
    localparam logic [6:0] RX = 7'b0000001;
    localparam logic [6:0] NO = 7'b0000000;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    // reference model state
    int m_tec, m_rec, m_st, m_bits, m_recov;
    bit m_tprev, m_rprev;

    can_fault_counters_if #(.RECOV_SEQ(128)) bus ();

    can_fault_counters dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [6:0] in;
        int         tec;
        int         rec;
        int         st;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_tec = 0; m_rec = 0; m_st = 0; m_bits = 0; m_recov = 0;
        m_tprev = 1'b0; m_rprev = 1'b0;
    endtask

    // One clock of the fault confinement rules.
    task automatic model_step(input logic [6:0] v);
        bit tg, rg;
        tg = v[6] | v[5];
        rg = v[4] | v[3] | v[2];
        if (m_st != 2) begin
            if (tg && !m_tprev) begin
                if (v[6]) begin
                    if (m_tec < 256) m_tec += 8;
                end else if (m_tec > 0) m_tec -= 1;
            end
            if (rg && !m_rprev) begin
                if (v[3])      m_rec = (m_rec + 8 > 511) ? 511 : m_rec + 8;
                else if (v[4]) m_rec = (m_rec + 1 > 511) ? 511 : m_rec + 1;
                else if (m_rec >= 128) m_rec = 120;
                else if (m_rec > 0)    m_rec -= 1;
            end
            if (m_tec >= 256) m_st = 2;
            else if (m_tec >= 128 || m_rec >= 128) m_st = 1;
            else m_st = 0;
        end else begin
            if (v[1]) begin
                if (v[0]) begin
                    m_bits++;
                    if (m_bits == 11) begin
                        m_bits = 0;
                        m_recov++;
                    end
                end else m_bits = 0;
            end
            if (m_recov == 128) begin
                m_tec = 0; m_rec = 0; m_recov = 0; m_bits = 0; m_st = 0;
            end
        end
        m_tprev = tg;
        m_rprev = rg;
    endtask

    task automatic check_model();
        chk("m_tec",   int'(bus.tec_count),   m_tec % 256);
        chk("m_rec",   int'(bus.rec_count),   m_rec % 256);
        chk("m_warn",  int'(bus.err_warning), (m_tec >= 96 || m_rec >= 96) ? 1 : 0);
        chk("m_state", int'(bus.fault_state), m_st);
        chk("m_busoff",int'(bus.bus_off),     (m_st == 2) ? 1 : 0);
        chk("m_recov", int'(bus.recov_count), m_recov);
    endtask

    task automatic drive(input logic [6:0] v);
        {bus.inc_tec8, bus.dec_tec, bus.inc_rec1, bus.inc_rec8,
         bus.dec_rec, bus.bit_tick, bus.rx_bit} = v;
    endtask

    task automatic apply(input logic [6:0] v);
        drive(v);
        @(posedge clock);
        model_step(v);
        #1;
        check_model();
    endtask

    task automatic pulse(input logic [6:0] v);
        apply(v);
        apply(NO);
    endtask

    task automatic hard_reset();
        drive(NO);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        check_model();
    endtask

    vec_t tab [12];

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(NO);
        model_reset();
        #2;
        chk("reset_tec",   int'(bus.tec_count),   0);
        chk("reset_state", int'(bus.fault_state), 0);
        chk("reset_recov", int'(bus.recov_count), 0);

        // ---- table-driven edge/priority vectors from reset ----
        tab[0]  = '{T8,       8,  0, 0};
        tab[1]  = '{T8,       8,  0, 0};
        tab[2]  = '{NO,       8,  0, 0};
        tab[3]  = '{T8 | TD, 16,  0, 0};
        tab[4]  = '{NO,      16,  0, 0};
        tab[5]  = '{TD,      15,  0, 0};
        tab[6]  = '{R8,      15,  8, 0};
        tab[7]  = '{R8 | R1, 15,  8, 0};
        tab[8]  = '{NO,      15,  8, 0};
        tab[9]  = '{R1,      15,  9, 0};
        tab[10] = '{NO,      15,  9, 0};
        tab[11] = '{RD | TD, 14,  8, 0};
        hard_reset();
        for (int i = 0; i < 12; i++) begin
            apply(tab[i].in);
            chk("tab_tec",   int'(bus.tec_count),   tab[i].tec);
            chk("tab_rec",   int'(bus.rec_count),   tab[i].rec);
            chk("tab_state", int'(bus.fault_state), tab[i].st);
        end

        // ---- TEC to warning, passive, hold and priority ----
        hard_reset();
        for (int i = 0; i < 12; i++) pulse(T8);
        chk("tec96",      int'(bus.tec_count),   96);
        chk("warn96",     int'(bus.err_warning), 1);
        chk("active96",   int'(bus.fault_state), 0);
        for (int i = 0; i < 4; i++) pulse(T8);
        chk("tec128",     int'(bus.tec_count),   128);
        chk("passive128", int'(bus.fault_state), 1);
        for (int i = 0; i < 10; i++) apply(T8);
        apply(NO);
        chk("hold_once",  int'(bus.tec_count),   136);
        pulse(T8 | TD);
        chk("inc_prio",   int'(bus.tec_count),   144);
        for (int i = 0; i < 13; i++) pulse(T8);
        chk("tec248",     int'(bus.tec_count),   248);
        pulse(T8);
        chk("tec256_lo",  int'(bus.tec_count),   0);
        chk("busoff",     int'(bus.bus_off),     1);
        chk("busoff_st",  int'(bus.fault_state), 2);
        pulse(T8);
        pulse(TD);
        chk("busoff_frz", int'(bus.bus_off),     1);

        // ---- recovery ----
        for (int i = 0; i < 10; i++) apply(TK | RX);
        apply(TK);
        for (int i = 0; i < 11; i++) apply(TK | RX);
        chk("recov1",     int'(bus.recov_count), 1);
        for (int i = 0; i < 127 * 11 - 1; i++) apply(TK | RX);
        chk("recov127",   int'(bus.recov_count), 127);
        chk("still_off",  int'(bus.fault_state), 2);
        apply(TK | RX);
        chk("rec_tec0",   int'(bus.tec_count),   0);
        chk("rec_rec0",   int'(bus.rec_count),   0);
        chk("rec_active", int'(bus.fault_state), 0);
        chk("rec_cnt0",   int'(bus.recov_count), 0);

        // ---- REC passive, reload, floor, saturation ----
        hard_reset();
        for (int i = 0; i < 16; i++) pulse(R8);
        chk("rec128",     int'(bus.rec_count),   128);
        chk("rec_pass",   int'(bus.fault_state), 1);
        pulse(RD);
        chk("reload120",  int'(bus.rec_count),   120);
        chk("reload_act", int'(bus.fault_state), 0);
        for (int i = 0; i < 120; i++) pulse(RD);
        chk("rec0",       int'(bus.rec_count),   0);
        pulse(RD);
        chk("rec0_hold",  int'(bus.rec_count),   0);
        for (int i = 0; i < 70; i++) pulse(R8);
        chk("rec_sat",    int'(bus.rec_count),   255);
        chk("rec_no_off", int'(bus.bus_off),     0);

        // ---- asynchronous reset during recovery ----
        hard_reset();
        for (int i = 0; i < 32; i++) pulse(T8);
        for (int i = 0; i < 550; i++) apply(TK | RX);
        chk("recov50",    int'(bus.recov_count), 50);
        drive(T8);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_tec",     int'(bus.tec_count),   0);
        chk("ar_state",   int'(bus.fault_state), 0);
        chk("ar_busoff",  int'(bus.bus_off),     0);
        chk("ar_recov",   int'(bus.recov_count), 0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        apply(T8);
        chk("post_rst_req", int'(bus.tec_count), 8);

        // ---- randomized against the model ----
        hard_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] v;
            v[6] = ($urandom_range(0, 2) == 0);
            v[5] = ($urandom_range(0, 3) == 0);
            v[4] = ($urandom_range(0, 3) == 0);
            v[3] = ($urandom_range(0, 3) == 0);
            v[2] = ($urandom_range(0, 3) == 0);
            v[1] = ($urandom_range(0, 1) == 0);
            v[0] = ($urandom_range(0, 15) != 0);
            apply(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
